// File: rtl/afifo_wr_arb.sv
// Round-robin write arbiter in front of an async FIFO write port.
// One requester owns the FIFO for a packet or up to MAX_BURST beats, whichever ends first.
module afifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wen,
    output logic [DATA_WIDTH-1:0]           fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    int               arb_s;
    logic             beat;
    logic             last_beat;

    // Circular search from rr_q; walking downward leaves the nearest hit last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        arb_s    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_s = int'(rr_q) + k;
            if (arb_s >= NUM_REQ) arb_s = arb_s - NUM_REQ;
            if (req_valid[arb_s]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(arb_s);
            end
        end
    end

    assign beat      = (state_q == GRANT) && req_valid[gnt_q] && !fifo_full;
    assign last_beat = beat && (req_last[gnt_q] || (cnt_q + 8'd1 == 8'(MAX_BURST)));

    assign fifo_wen   = beat;
    assign fifo_wdata = req_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready  = beat ? (NUM_REQ'(1) << gnt_q) : '0;
    assign grant_id   = gnt_q;
    assign busy       = (state_q == GRANT);

    // No timeout in GRANT: an owner that stalls mid-packet keeps the FIFO.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = pick_idx;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                if (beat) cnt_d = cnt_q + 8'd1;
                if (last_beat) begin
                    state_d = IDLE;
                    rr_d    = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/afifo_wr_arb.md
AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of write requesters (2..8).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, giving the FIFO word width.
REQ-003 The module SHALL have parameter MAX_BURST, default 8, giving the maximum beats per grant (1..255).
REQ-004 The module SHALL have port wclk, input, 1 bit: the single clock, i.e. the FIFO write clock.
REQ-005 The module SHALL have port wrst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port req_valid, input, NUM_REQ bits: per-requester word valid.
REQ-007 The module SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: the per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The module SHALL have port req_last, input, NUM_REQ bits: marks the final word of a requester's packet.
REQ-009 The module SHALL have port req_ready, output, NUM_REQ bits: per-requester word accepted.
REQ-010 The module SHALL have port fifo_full, input, 1 bit: full flag from the async FIFO write side.
REQ-011 The module SHALL have port fifo_wen, output, 1 bit: FIFO write enable.
REQ-012 The module SHALL have port fifo_wdata, output, DATA_WIDTH bits: FIFO write data.
REQ-013 The module SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current owner.
REQ-014 The module SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and GRANT, held in a registered state variable.
REQ-016 In IDLE with any req_valid high, the module SHALL select the first requester with valid high, searching circularly from rr_ptr upward, register it as grant_id and go to GRANT on the next edge (1-cycle arbitration latency).
REQ-017 In IDLE with no req_valid high, the module SHALL stay in IDLE; grant_id SHALL hold its last value.
REQ-018 In GRANT, a beat SHALL occur when req_valid[grant_id]=1 and fifo_full=0; fifo_wen and req_ready[grant_id] SHALL be combinationally high in that cycle only.
REQ-019 fifo_wdata SHALL equal the grant_id slice of req_data in all cycles; it is a don't-care when fifo_wen=0.
REQ-020 req_ready SHALL be 0 for all non-owners, for all requesters in IDLE, and for all requesters while fifo_full=1.
REQ-021 A beat counter (8 bits) SHALL reset to 0 on entry to GRANT and increment per beat.
REQ-022 GRANT SHALL exit to IDLE after a beat with req_last[grant_id]=1 (packet end) or after the beat that makes the count equal MAX_BURST (forced release), whichever comes first.
REQ-023 On GRANT exit, rr_ptr SHALL become grant_id+1, wrapping NUM_REQ-1 to 0.
REQ-024 If the owner drops req_valid mid-packet, the module SHALL hold GRANT indefinitely (packet lock); other requesters SHALL NOT be served.
REQ-025 While fifo_full=1 in GRANT, the state and the beat count SHALL hold; no word is lost or duplicated.
REQ-026 Sustained throughput SHALL be MAX_BURST beats per MAX_BURST+1 cycles when the FIFO never fills (one IDLE cycle per grant).

Reset
REQ-027 On wrst_n=0, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, beat count=0, busy=0, fifo_wen=0, req_ready=0.
REQ-028 Reset asserted mid-packet SHALL abandon the grant; after deassertion, arbitration SHALL restart from requester 0.

Verification
REQ-029 Test: req_valid=4'b1111, every word with last=1, fifo_full=0 -> grant order 0,1,2,3,0, with one beat each and fifo_wen on alternate cycles.
REQ-030 Test: requester 2 sends a 3-word packet (last on word 3) while requester 1 is valid -> words A,B,C from 2 are written contiguously; requester 1 is granted next.
REQ-031 Test: MAX_BURST=8, requester 0 streams 12 words without last while requester 3 is valid -> 8 words from 0, then requester 3 is granted, then the remaining 4 words from 0.
REQ-032 Test: fifo_full=1 for 5 cycles mid-burst -> fifo_wen=0 and req_ready=0 for those cycles, beat count frozen, next word written when full drops.
REQ-033 Test: owner drops valid for 3 cycles mid-packet while others are valid -> busy stays 1, grant_id unchanged, no foreign writes.
REQ-034 Test: wrst_n pulsed low mid-packet from requester 2 -> all outputs 0 immediately; the first grant after reset goes to the lowest valid index.
